mealy_table_fsm: RTL



---
 rtl/mealy_table_pkg.sv | 24 ++
 rtl/mealy_table_mem.sv | 45 ++++
 rtl/mealy_table_fsm.sv | 90 +++++++++
 3 files changed

// File: rtl/mealy_table_pkg.sv
// Shared types and constants for the table-driven Mealy machine.
// The classic exercise table applies only to the 3-bit state / 1-bit in / 1-bit out build.
package mealy_table_pkg;

  localparam int TRANS_CNT_W = 16;

  typedef struct packed {
    logic [2:0] next;
    logic       out;
  } entry_t;

  // Index is {state, in}; element 0 is S0/in0.
  localparam entry_t DEFAULT_TABLE [16] = '{
    '{3'd0, 1'b0}, '{3'd3, 1'b1},  // S0
    '{3'd2, 1'b1}, '{3'd4, 1'b1},  // S1
    '{3'd5, 1'b1}, '{3'd0, 1'b0},  // S2
    '{3'd1, 1'b0}, '{3'd7, 1'b1},  // S3
    '{3'd7, 1'b1}, '{3'd1, 1'b0},  // S4
    '{3'd7, 1'b1}, '{3'd6, 1'b1},  // S5
    '{3'd5, 1'b0}, '{3'd7, 1'b1},  // S6
    '{3'd7, 1'b0}, '{3'd1, 1'b0}   // S7
  };

endpackage

// File: rtl/mealy_table_mem.sv
// Register table of {next, out} entries with reset-default contents,
// one write port and one combinational read port.
module mealy_table_mem
  import mealy_table_pkg::*;
#(
  parameter int STATE_W = 3,
  parameter int IN_W    = 1,
  parameter int OUT_W   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [STATE_W+IN_W-1:0]    cfg_addr,
  input  logic [STATE_W+OUT_W-1:0]   cfg_data,
  input  logic [STATE_W+IN_W-1:0]    rd_addr,
  output logic [STATE_W+OUT_W-1:0]   rd_data
);

  localparam int ADDR_W  = STATE_W + IN_W;
  localparam int ENTRY_W = STATE_W + OUT_W;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam bit IS_CLASSIC = (STATE_W == 3) && (IN_W == 1) && (OUT_W == 1);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Non-classic builds default to a self-loop in every state with output 0.
  function automatic logic [ENTRY_W-1:0] default_entry(input int unsigned idx);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(idx);
    if (IS_CLASSIC) return ENTRY_W'(DEFAULT_TABLE[idx[3:0]]);
    else            return {a[ADDR_W-1 -: STATE_W], {OUT_W{1'b0}}};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= default_entry(i);
    end else if (cfg_we) begin
      mem[cfg_addr] <= cfg_data;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not observed.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mealy_table_fsm.sv
// Table-driven Mealy FSM: registered state/out, priority reset > load > step > hold.
// Optional saturating state-change counter enabled by FSM_TRANS_CNT_EN.
module mealy_table_fsm
  import mealy_table_pkg::*;
#(
  parameter int STATE_W = 3,
  parameter int IN_W    = 1,
  parameter int OUT_W   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step,
  input  logic [IN_W-1:0]            in,
  input  logic                       load_en,
  input  logic [STATE_W-1:0]         load_state,
  input  logic                       cfg_we,
  input  logic [STATE_W+IN_W-1:0]    cfg_addr,
  input  logic [STATE_W+OUT_W-1:0]   cfg_data,
`ifdef FSM_TRANS_CNT_EN
  output logic [TRANS_CNT_W-1:0]     trans_cnt,
`endif
  output logic [OUT_W-1:0]           out,
  output logic [STATE_W-1:0]         state
);

  localparam int ENTRY_W = STATE_W + OUT_W;

  logic [STATE_W-1:0] state_q, state_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [ENTRY_W-1:0] entry;
  logic [STATE_W-1:0] entry_next;
  logic [OUT_W-1:0]   entry_out;

  mealy_table_mem #(
    .STATE_W (STATE_W),
    .IN_W    (IN_W),
    .OUT_W   (OUT_W)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .rd_addr  ({state_q, in}),
    .rd_data  (entry)
  );

  assign entry_next = entry[ENTRY_W-1 -: STATE_W];
  assign entry_out  = entry[OUT_W-1:0];

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    if (load_en) begin
      state_d = load_state;
    end else if (step) begin
      state_d = entry_next;
      out_d   = entry_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign state = state_q;
  assign out   = out_q;

`ifdef FSM_TRANS_CNT_EN
  logic [TRANS_CNT_W-1:0] trans_cnt_q;

  // state_d only differs from state_q on a load or step edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      trans_cnt_q <= '0;
    end else if ((state_d != state_q) && (trans_cnt_q != {TRANS_CNT_W{1'b1}})) begin
      trans_cnt_q <= trans_cnt_q + TRANS_CNT_W'(1);
    end
  end

  assign trans_cnt = trans_cnt_q;
`endif

endmodule
